// File: rtl/apb_i2c_pkg.sv
// Shared types and address-field constants for the APB register bridge.
package apb_i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

    localparam logic [2:0] REG_APB_IDX = 3'd7;

    // paddr[1:0] must be zero, paddr[4:2] selects the register, bits above must be zero
    localparam int REG_SEL_LSB = 2;
    localparam int REG_SEL_MSB = 4;
    localparam int ADDR_HI_LSB = 5;

    localparam int CTR_W = 3;

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable wait-state down-counter; o_done flags terminal count (zero).
module apb_wait_ctr
    import apb_i2c_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CTR_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [CTR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/apb_reg_bridge.sv
// APB slave bridge onto a small register file: APB writes land in register 7,
// reads return through the register file's combinational read port.
module apb_reg_bridge
    import apb_i2c_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              rf_write_en,
    output logic              rf_apb_op,
    output logic [7:0]        rf_apb_data,
    output logic [2:0]        rf_read_addr,
    input  logic [7:0]        rf_read_data
);
    // state  | meaning
    // IDLE   | bus idle, waiting for a setup phase
    // SETUP  | address/control/data latched, waiting for penable
    // ACCESS | wait states counting down; psel/penable drop aborts
    // DONE   | one-cycle pready with response and write strobe

    localparam logic [CTR_W-1:0] WAIT_LOAD = CTR_W'(WAIT_CYCLES);

    apb_state_e        r_state;
    apb_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [7:0]        r_pwdata;
    logic              r_pready;
    logic              r_pslverr;
    logic              r_write_en;
    logic [7:0]        r_prdata;
    logic              w_latch;
    logic              w_ctr_load;
    logic              w_ctr_done;
    logic              w_to_done;
    logic              w_err;

    apb_wait_ctr u_wait_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_ctr_load),
        .i_load_val (WAIT_LOAD),
        .i_en       (r_state == ST_ACCESS),
        .o_done     (w_ctr_done)
    );

    assign w_err = (r_paddr[REG_SEL_LSB-1:0] != '0)
                || (r_paddr[ADDR_W-1:ADDR_HI_LSB] != '0)
                || (r_pwrite && (r_paddr[REG_SEL_MSB:REG_SEL_LSB] != REG_APB_IDX));

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_ctr_load  = 1'b0;
        w_to_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    w_state_nxt = ST_SETUP;
                    w_latch     = 1'b1;
                end
            end
            ST_SETUP: begin
                if (!psel) begin
                    w_state_nxt = ST_IDLE;
                end else if (penable) begin
                    w_state_nxt = ST_ACCESS;
                    w_ctr_load  = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!(psel && penable)) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ctr_done) begin
                    w_state_nxt = ST_DONE;
                    w_to_done   = 1'b1;
                end
            end
            ST_DONE: begin
                if (psel && !penable) begin
                    w_state_nxt = ST_SETUP;
                    w_latch     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_paddr    <= '0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= 8'h00;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_write_en <= 1'b0;
            r_prdata   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_paddr  <= paddr;
                r_pwrite <= pwrite;
                r_pwdata <= pwdata;
            end
            // Response registers are only ever set on the edge into DONE,
            // so they read zero in every other state.
            r_pready   <= w_to_done;
            r_pslverr  <= w_to_done && w_err;
            r_write_en <= w_to_done && !w_err && r_pwrite;
            r_prdata   <= (w_to_done && !w_err && !r_pwrite) ? rf_read_data : 8'h00;
        end
    end

    // The register file captures on the same edge that resets us, so the strobe
    // has to die combinationally with rst_n.
    assign rf_write_en  = r_write_en & rst_n;
    assign rf_apb_op    = r_write_en & rst_n;
    assign rf_apb_data  = r_pwdata;
    assign rf_read_addr = r_paddr[REG_SEL_MSB:REG_SEL_LSB];
    assign prdata       = r_prdata;
    assign pready       = r_pready;
    assign pslverr      = r_pslverr;

endmodule
